// File: rtl/axil_regfile_n.sv
// axil_regfile_n: parametrised AXI4-Lite slave register file with RW control and RO status registers
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*         AXI4-Lite read address and data channels
//   ctrl_out             flattened RW registers, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   status_in            flattened RO register sources, same packing
//   wr_pulse             one-cycle strobe per RW register after a committed write
module axil_regfile_n #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_RW     = 4,
    parameter int                    NUM_RO     = 2,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                                              ACLK,
    input  logic                                              ARESET,
    input  logic [ADDR_WIDTH-1:0]                             S_AXI_AWADDR,
    input  logic [2:0]                                        S_AXI_AWPROT,
    input  logic                                              S_AXI_AWVALID,
    output logic                                              S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                             S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                           S_AXI_WSTRB,
    input  logic                                              S_AXI_WVALID,
    output logic                                              S_AXI_WREADY,
    output logic [1:0]                                        S_AXI_BRESP,
    output logic                                              S_AXI_BVALID,
    input  logic                                              S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                             S_AXI_ARADDR,
    input  logic [2:0]                                        S_AXI_ARPROT,
    input  logic                                              S_AXI_ARVALID,
    output logic                                              S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                             S_AXI_RDATA,
    output logic [1:0]                                        S_AXI_RRESP,
    output logic                                              S_AXI_RVALID,
    input  logic                                              S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0]                      ctrl_out,
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in,
    output logic [NUM_RW-1:0]                                 wr_pulse
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;

    logic [0:0]            r_wstate, r_rstate;
    logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [NB-1:0]         r_wstrb;

    logic                  w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit, w_wr_ok, w_rerr;
    logic [ADDR_WIDTH-1:0] w_waddr, w_widx, w_ridx;
    logic [DATA_WIDTH-1:0] w_wdat, w_rdata;
    logic [NB-1:0]         w_wstb;
    logic                  w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in};

    // In W_IDLE a dropped READY means that half of the write is already latched.
    assign w_aw_hs   = S_AXI_AWVALID & r_awready;
    assign w_w_hs    = S_AXI_WVALID & r_wready;
    assign w_have_aw = w_aw_hs | (r_wstate == W_IDLE && !r_awready);
    assign w_have_w  = w_w_hs | (r_wstate == W_IDLE && !r_wready);
    assign w_commit  = w_have_aw & w_have_w;
    assign w_waddr   = w_aw_hs ? S_AXI_AWADDR : r_awaddr;
    assign w_wdat    = w_w_hs ? S_AXI_WDATA : r_wdata;
    assign w_wstb    = w_w_hs ? S_AXI_WSTRB : r_wstrb;
    assign w_widx    = w_waddr >> LSB;
    assign w_wr_ok   = w_widx < ADDR_WIDTH'(NUM_RW);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else if (r_wstate == W_RESP) begin
            if (S_AXI_BREADY) begin
                r_wstate  <= W_IDLE;
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end else begin
            if (w_aw_hs) begin
                r_awaddr  <= S_AXI_AWADDR;
                r_awready <= 1'b0;
            end
            if (w_w_hs) begin
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
                r_wready <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw
        logic [DATA_WIDTH-1:0] r_reg;
        logic                  r_pulse;
        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                r_reg   <= RESET_VAL;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_commit && w_widx == ADDR_WIDTH'(k);
                if (w_commit && w_widx == ADDR_WIDTH'(k))
                    for (int b = 0; b < NB; b++)
                        if (w_wstb[b]) r_reg[8*b +: 8] <= w_wdat[8*b +: 8];
            end
        end
        assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = r_reg;
        assign wr_pulse[k] = r_pulse;
    end

    // Read mux looks at the registered values, so a read on a commit edge sees the old data.
    assign w_ridx = S_AXI_ARADDR >> LSB;

    always_comb begin
        w_rdata = '0;
        w_rerr  = 1'b1;
        for (int k = 0; k < NUM_RW; k++)
            if (w_ridx == ADDR_WIDTH'(k)) begin
                w_rdata = ctrl_out[k*DATA_WIDTH +: DATA_WIDTH];
                w_rerr  = 1'b0;
            end
        for (int j = 0; j < NUM_RO; j++)
            if (w_ridx == ADDR_WIDTH'(NUM_RW + j)) begin
                w_rdata = status_in[j*DATA_WIDTH +: DATA_WIDTH];
                w_rerr  = 1'b0;
            end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else if (r_rstate == R_IDLE) begin
            if (S_AXI_ARVALID) begin
                r_rstate  <= R_DATA;
                r_rdata   <= w_rdata;
                r_rresp   <= w_rerr ? 2'b10 : 2'b00;
                r_rvalid  <= 1'b1;
                r_arready <= 1'b0;
            end
        end else if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_axil_regfile_n.sv
// tb_axil_regfile_n: directed bench for a 32-bit/6-register and a 64-bit/8-register axil_regfile_n
module tb_axil_regfile_n;
    localparam logic [63:0] RV64 = 64'hA5A5_0000_0000_5A5A;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    logic        sel = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;

    logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    logic [1:0]   a_bresp, a_rresp;
    logic [31:0]  a_rdata;
    logic [127:0] a_ctrl;
    logic [63:0]  a_status = '0;
    logic [3:0]   a_pulse;
    logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
    logic [1:0]   b_bresp, b_rresp;
    logic [63:0]  b_rdata;
    logic [511:0] b_ctrl;
    logic [63:0]  b_status = '0;
    logic [7:0]   b_pulse;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;
    assign awready = sel ? b_awready : a_awready;
    assign wready  = sel ? b_wready : a_wready;
    assign bvalid  = sel ? b_bvalid : a_bvalid;
    assign bresp   = sel ? b_bresp : a_bresp;
    assign arready = sel ? b_arready : a_arready;
    assign rvalid  = sel ? b_rvalid : a_rvalid;
    assign rresp   = sel ? b_rresp : a_rresp;
    assign rdata   = sel ? b_rdata : {32'h0, a_rdata};

    int ntests = 0, errs = 0;
    int a_pc[4] = '{default: 0};
    int b_pc[8] = '{default: 0};

    always @(negedge ACLK) begin
        for (int k = 0; k < 4; k++) if (a_pulse[k] === 1'b1) a_pc[k]++;
        for (int k = 0; k < 8; k++) if (b_pulse[k] === 1'b1) b_pc[k]++;
    end

    axil_regfile_n u_a (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & ~sel), .S_AXI_AWREADY(a_awready),
        .S_AXI_WDATA(wdata[31:0]), .S_AXI_WSTRB(wstrb[3:0]), .S_AXI_WVALID(wvalid & ~sel), .S_AXI_WREADY(a_wready),
        .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(bready & ~sel),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & ~sel), .S_AXI_ARREADY(a_arready),
        .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(rready & ~sel),
        .ctrl_out(a_ctrl), .status_in(a_status), .wr_pulse(a_pulse)
    );

    axil_regfile_n #(.DATA_WIDTH(64), .NUM_RW(8), .NUM_RO(0), .ADDR_WIDTH(6), .RESET_VAL(RV64)) u_b (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & sel), .S_AXI_AWREADY(b_awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid & sel), .S_AXI_WREADY(b_wready),
        .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(bready & sel),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & sel), .S_AXI_ARREADY(b_arready),
        .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(rready & sel),
        .ctrl_out(b_ctrl), .status_in(b_status), .wr_pulse(b_pulse)
    );

    // Tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [5:0] addr, input logic [63:0] data, input logic [7:0] strb, output logic [1:0] resp);
        bit aw_d, w_d, done;
        done = 0;
        resp = 'x;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            aw_d = awvalid && awready;
            w_d  = wvalid && wready;
            @(posedge ACLK); #1;
            if (aw_d) awvalid = 0;
            if (w_d) wvalid = 0;
            if (bvalid) begin resp = bresp; done = 1; end
        end
        ntests++; if (!done) begin $display("FAIL wr_timeout addr=%h no BVALID within 20 cycles", addr); errs++; awvalid = 0; wvalid = 0; end
        @(posedge ACLK); #1;
        bready = 0;
    endtask

    task automatic rd(input logic [5:0] addr, output logic [63:0] data, output logic [1:0] resp);
        bit ar_d, done;
        done = 0;
        data = 'x; resp = 'x;
        araddr = addr; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            ar_d = arvalid && arready;
            @(posedge ACLK); #1;
            if (ar_d) arvalid = 0;
            if (rvalid) begin data = rdata; resp = rresp; done = 1; end
        end
        ntests++; if (!done) begin $display("FAIL rd_timeout addr=%h no RVALID within 20 cycles", addr); errs++; arvalid = 0; end
        @(posedge ACLK); #1;
        rready = 0;
    endtask

    task automatic test_reset;
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        #1;
        ntests++; if ({a_awready, a_wready, a_arready, a_bvalid, a_rvalid} !== 5'b11100) begin $display("FAIL a_rst_hs got=%b exp=11100", {a_awready, a_wready, a_arready, a_bvalid, a_rvalid}); errs++; end
        ntests++; if ({a_bresp, a_rresp, a_rdata, a_pulse} !== '0) begin $display("FAIL a_rst_out got=%h exp=0", {a_bresp, a_rresp, a_rdata, a_pulse}); errs++; end
        ntests++; if (a_ctrl !== '0) begin $display("FAIL a_rst_ctrl got=%h exp=0", a_ctrl); errs++; end
        ntests++; if ({b_awready, b_wready, b_arready, b_bvalid, b_rvalid} !== 5'b11100) begin $display("FAIL b_rst_hs got=%b exp=11100", {b_awready, b_wready, b_arready, b_bvalid, b_rvalid}); errs++; end
        ntests++; if ({b_bresp, b_rresp, b_rdata, b_pulse} !== '0) begin $display("FAIL b_rst_out got=%h exp=0", {b_bresp, b_rresp, b_rdata, b_pulse}); errs++; end
        ntests++; if (b_ctrl !== {8{RV64}}) begin $display("FAIL b_rst_ctrl got=%h exp=%h", b_ctrl, {8{RV64}}); errs++; end
        ARESET = 0;
    endtask

    task automatic test_basic;
        logic [63:0] d;
        logic [1:0]  r;
        int          pc;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            pc = a_pc[i];
            wr(6'(4 * i), 64'(i + 1), 8'hF, r);
            ntests++; if (r !== 2'b00) begin $display("FAIL basic_bresp reg=%0d got=%b exp=00", i, r); errs++; end
            ntests++; if (a_pc[i] - pc !== 1) begin $display("FAIL basic_pulse reg=%0d got=%0d cycles exp=1", i, a_pc[i] - pc); errs++; end
        end
        ntests++; if (a_ctrl !== {32'd4, 32'd3, 32'd2, 32'd1}) begin $display("FAIL basic_ctrl got=%h exp=00000004000000030000000200000001", a_ctrl); errs++; end
        for (int i = 0; i < 4; i++) begin
            rd(6'(4 * i), d, r);
            ntests++; if ({r, d} !== {2'b00, 64'(i + 1)}) begin $display("FAIL basic_read reg=%0d got=%b/%h exp=00/%h", i, r, d, 64'(i + 1)); errs++; end
        end
    endtask

    task automatic test_strobe;
        logic [63:0] d;
        logic [1:0]  r;
        int          pc;
        wr(6'h0, 64'hAABBCCDD, 8'hF, r);
        wr(6'h0, 64'h11223344, 8'h5, r);
        rd(6'h0, d, r);
        ntests++; if (d !== 64'hAA22CC44) begin $display("FAIL strobe_merge got=%h exp=aa22cc44", d); errs++; end
        pc = a_pc[0];
        wr(6'h0, 64'hFFFFFFFF, 8'h0, r);
        ntests++; if (a_ctrl[31:0] !== 32'hAA22CC44) begin $display("FAIL strobe_zero_data got=%h exp=aa22cc44", a_ctrl[31:0]); errs++; end
        ntests++; if (a_pc[0] - pc !== 1) begin $display("FAIL strobe_zero_pulse got=%0d exp=1", a_pc[0] - pc); errs++; end
    endtask

    task automatic test_w_first;
        int pc;
        pc = a_pc[1];
        wdata = 64'h77; wstrb = 8'hF; wvalid = 1; bready = 0;
        @(posedge ACLK); #1;
        wvalid = 0;
        ntests++; if ({wready, bvalid} !== 2'b00) begin $display("FAIL wfirst_latched got=%b exp=00", {wready, bvalid}); errs++; end
        @(posedge ACLK); #1;
        ntests++; if ({bvalid, a_ctrl[63:32]} !== {1'b0, 32'd2}) begin $display("FAIL wfirst_wait got=%h exp=0/2", {bvalid, a_ctrl[63:32]}); errs++; end
        awaddr = 6'h4; awvalid = 1;
        @(posedge ACLK); #1;
        awvalid = 0;
        ntests++; if ({bvalid, bresp, awready} !== 4'b1000) begin $display("FAIL wfirst_commit got=%b exp=1000", {bvalid, bresp, awready}); errs++; end
        ntests++; if (a_ctrl[63:32] !== 32'h77) begin $display("FAIL wfirst_ctrl got=%h exp=77", a_ctrl[63:32]); errs++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            ntests++; if ({bvalid, bresp} !== 3'b100) begin $display("FAIL wfirst_hold cycle=%0d got=%b exp=100", i, {bvalid, bresp}); errs++; end
        end
        bready = 1;
        @(posedge ACLK); #1;
        bready = 0;
        ntests++; if ({bvalid, awready, wready} !== 3'b011) begin $display("FAIL wfirst_release got=%b exp=011", {bvalid, awready, wready}); errs++; end
        ntests++; if (a_pc[1] - pc !== 1) begin $display("FAIL wfirst_pulse got=%0d exp=1", a_pc[1] - pc); errs++; end
    endtask

    task automatic test_status;
        logic [63:0]  d;
        logic [1:0]   r;
        logic [127:0] c;
        int           ps;
        a_status = {32'h12345678, 32'hDEADBEEF};
        rd(6'h10, d, r);
        ntests++; if ({r, d} !== {2'b00, 64'hDEADBEEF}) begin $display("FAIL ro_read got=%b/%h exp=00/deadbeef", r, d); errs++; end
        rd(6'h13, d, r);
        ntests++; if ({r, d} !== {2'b00, 64'hDEADBEEF}) begin $display("FAIL ro_unaligned got=%b/%h exp=00/deadbeef", r, d); errs++; end
        c = a_ctrl;
        ps = a_pc[0] + a_pc[1] + a_pc[2] + a_pc[3];
        wr(6'h10, 64'h0, 8'hF, r);
        ntests++; if (r !== 2'b10) begin $display("FAIL ro_write_resp got=%b exp=10", r); errs++; end
        rd(6'h10, d, r);
        ntests++; if (d !== 64'hDEADBEEF) begin $display("FAIL ro_after_write got=%h exp=deadbeef", d); errs++; end
        rd(6'h18, d, r);
        ntests++; if ({r, d} !== {2'b10, 64'h0}) begin $display("FAIL oor_read got=%b/%h exp=10/0", r, d); errs++; end
        wr(6'h18, 64'hFFFFFFFF, 8'hF, r);
        ntests++; if (r !== 2'b10) begin $display("FAIL oor_write_resp got=%b exp=10", r); errs++; end
        ntests++; if (a_ctrl !== c) begin $display("FAIL bad_write_ctrl got=%h exp=%h", a_ctrl, c); errs++; end
        ntests++; if (a_pc[0] + a_pc[1] + a_pc[2] + a_pc[3] !== ps) begin $display("FAIL bad_write_pulse got=%0d exp=%0d", a_pc[0] + a_pc[1] + a_pc[2] + a_pc[3], ps); errs++; end
        araddr = 6'h14; arvalid = 1;
        @(posedge ACLK); #1;
        arvalid = 0;
        a_status[63:32] = 32'h0;
        @(posedge ACLK); #1;
        ntests++; if ({rvalid, rdata} !== {1'b1, 64'h12345678}) begin $display("FAIL ro_snapshot got=%h exp=1/12345678", {rvalid, rdata}); errs++; end
        rready = 1;
        @(posedge ACLK); #1;
        rready = 0;
        ntests++; if ({rvalid, arready} !== 2'b01) begin $display("FAIL r_release got=%b exp=01", {rvalid, arready}); errs++; end
    endtask

    task automatic test_same_edge;
        logic [63:0] d;
        logic [1:0]  r;
        awaddr = 6'h8; wdata = 64'h5; wstrb = 8'hF; araddr = 6'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        ntests++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 64'h3}) begin $display("FAIL same_edge_old got=%h exp=1/0/3", {rvalid, rresp, rdata}); errs++; end
        ntests++; if ({bvalid, a_ctrl[95:64]} !== {1'b1, 32'h5}) begin $display("FAIL same_edge_commit got=%h exp=1/5", {bvalid, a_ctrl[95:64]}); errs++; end
        bready = 1; rready = 1;
        @(posedge ACLK); #1;
        bready = 0; rready = 0;
        rd(6'h8, d, r);
        ntests++; if (d !== 64'h5) begin $display("FAIL same_edge_new got=%h exp=5", d); errs++; end
    endtask

    task automatic test_wide;
        logic [63:0] d;
        logic [1:0]  r;
        int          pc1, pc7;
        sel = 1;
        pc1 = b_pc[1]; pc7 = b_pc[7];
        wr(6'h08, 64'h1122334455667788, 8'hFF, r);
        ntests++; if (r !== 2'b00) begin $display("FAIL wide_bresp got=%b exp=00", r); errs++; end
        wr(6'h08, 64'hAABBCCDDEEFF0011, 8'h81, r);
        rd(6'h0C, d, r);
        ntests++; if ({r, d} !== {2'b00, 64'hAA22334455667711}) begin $display("FAIL wide_strobe got=%b/%h exp=00/aa22334455667711", r, d); errs++; end
        ntests++; if (b_pc[1] - pc1 !== 2) begin $display("FAIL wide_pulse got=%0d exp=2", b_pc[1] - pc1); errs++; end
        rd(6'h38, d, r);
        ntests++; if (d !== RV64) begin $display("FAIL wide_reg7_reset got=%h exp=%h", d, RV64); errs++; end
        wr(6'h38, 64'h0, 8'h0F, r);
        ntests++; if (b_ctrl[7*64 +: 64] !== 64'hA5A5_0000_0000_0000) begin $display("FAIL wide_reg7_lanes got=%h exp=a5a5000000000000", b_ctrl[7*64 +: 64]); errs++; end
        ntests++; if (b_pc[7] - pc7 !== 1) begin $display("FAIL wide_reg7_pulse got=%0d exp=1", b_pc[7] - pc7); errs++; end
        ntests++; if ({b_ctrl[0 +: 64], b_ctrl[2*64 +: 64]} !== {RV64, RV64}) begin $display("FAIL wide_stride got=%h exp=%h", {b_ctrl[0 +: 64], b_ctrl[2*64 +: 64]}, {RV64, RV64}); errs++; end
        sel = 0;
    endtask

    task automatic test_reset_mid;
        sel = 0;
        awaddr = 6'hC; wdata = 64'h99; wstrb = 8'hF; araddr = 6'h0;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        ntests++; if ({bvalid, rvalid} !== 2'b11) begin $display("FAIL mid_setup got=%b exp=11", {bvalid, rvalid}); errs++; end
        ARESET = 1;
        @(posedge ACLK); #1;
        ARESET = 0;
        ntests++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin $display("FAIL mid_reset_hs got=%b exp=00111", {bvalid, rvalid, awready, wready, arready}); errs++; end
        ntests++; if ({a_ctrl, rdata} !== '0) begin $display("FAIL mid_reset_regs got=%h exp=0", {a_ctrl, rdata}); errs++; end
        ntests++; if (b_ctrl !== {8{RV64}}) begin $display("FAIL mid_reset_wide got=%h exp=%h", b_ctrl, {8{RV64}}); errs++; end
        @(posedge ACLK); #1;
        ntests++; if ({bvalid, rvalid} !== 2'b00) begin $display("FAIL mid_no_resp got=%b exp=00", {bvalid, rvalid}); errs++; end
        wdata = 64'hABCD; wvalid = 1;
        @(posedge ACLK); #1;
        wvalid = 0;
        ARESET = 1;
        @(posedge ACLK); #1;
        ARESET = 0;
        awaddr = 6'h0; awvalid = 1; bready = 1;
        @(posedge ACLK); #1;
        awvalid = 0;
        ntests++; if ({bvalid, awready, wready} !== 3'b001) begin $display("FAIL mid_discard got=%b exp=001", {bvalid, awready, wready}); errs++; end
        wdata = 64'h55; wvalid = 1;
        @(posedge ACLK); #1;
        wvalid = 0;
        ntests++; if ({bvalid, a_ctrl[31:0]} !== {1'b1, 32'h55}) begin $display("FAIL mid_fresh_write got=%h exp=1/55", {bvalid, a_ctrl[31:0]}); errs++; end
        @(posedge ACLK); #1;
        bready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_w_first();
        test_status();
        test_same_edge();
        test_wide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, errs);
        $finish;
    end
endmodule
